// File: rtl/axi_full_mst_line.sv
// axi_full_mst_line
//   Cache-line burst master. It takes one whole-line refill or writeback
//   request, buffers the line, and issues a single INCR burst of BEAT_NUM
//   beats of DW bits on an AXI4 full bus. When the burst ends it gives a
//   one-cycle completion pulse with the assembled line and an error flag.
//
//   Optional feature: define AXI_MST_RESP_CHK_EN to report BRESP/RRESP
//   errors and RLAST/beat-count mismatches on rsp_err. When it is not
//   defined, rsp_err is tied to 0.
//
// Ports
//   CLK, RSTn             clock (rising edge); async active-low reset
//   req_valid/ready       request handshake; ready only in IDLE
//   req_wr                1 = writeback, 0 = refill
//   req_addr              line address; the in-line offset bits are dropped
//   req_wdata             writeback line; beat i = [i*DW +: DW]
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             line buffer (refill data); valid with rsp_valid
//   rsp_err               completion error status
//   MEM_AW*/W*/B*/AR*/R*  AXI4 master channels toward the SRAM slave
module axi_full_mst_line #(
   parameter int DW       = 64,
   parameter int BEAT_NUM = 8
) (
   input  logic                   CLK,
   input  logic                   RSTn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_wr,
   input  logic [31:0]            req_addr,
   input  logic [DW*BEAT_NUM-1:0] req_wdata,
   output logic                   rsp_valid,
   output logic [DW*BEAT_NUM-1:0] rsp_rdata,
   output logic                   rsp_err,
   output logic [31:0]            MEM_AWADDR,
   output logic [7:0]             MEM_AWLEN,
   output logic [2:0]             MEM_AWSIZE,
   output logic [1:0]             MEM_AWBURST,
   output logic                   MEM_AWVALID,
   input  logic                   MEM_AWREADY,
   output logic [DW-1:0]          MEM_WDATA,
   output logic [DW/8-1:0]        MEM_WSTRB,
   output logic                   MEM_WLAST,
   output logic                   MEM_WVALID,
   input  logic                   MEM_WREADY,
   input  logic [1:0]             MEM_BRESP,
   input  logic                   MEM_BVALID,
   output logic                   MEM_BREADY,
   output logic [31:0]            MEM_ARADDR,
   output logic [7:0]             MEM_ARLEN,
   output logic [2:0]             MEM_ARSIZE,
   output logic [1:0]             MEM_ARBURST,
   output logic                   MEM_ARVALID,
   input  logic                   MEM_ARREADY,
   input  logic [DW-1:0]          MEM_RDATA,
   input  logic [1:0]             MEM_RRESP,
   input  logic                   MEM_RLAST,
   input  logic                   MEM_RVALID,
   output logic                   MEM_RREADY
);

   localparam int          LINE_BYTES = DW / 8 * BEAT_NUM;
   localparam int          OFF_W      = $clog2(LINE_BYTES);
   localparam int          IW         = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
   localparam logic [7:0]  LAST_CNT   = 8'(BEAT_NUM - 1);
   localparam logic [31:0] ADDR_MASK  = ~((32'd1 << OFF_W) - 32'd1);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP
   } state_t;

   state_t                       state, state_nxt;
   logic [7:0]                   cnt;
   logic [BEAT_NUM-1:0][DW-1:0]  line_buf;
   logic [31:0]                  addr;
   // Low until the first clock after reset release, so req_ready stays 0
   // while RSTn is held low even though the FSM sits in IDLE.
   logic                         started;

   logic          accept, w_hs, r_hs, cnt_last, r_done;
   logic [IW-1:0] idx;

   assign accept   = req_valid & req_ready;
   assign w_hs     = MEM_WVALID & MEM_WREADY;
   assign r_hs     = MEM_RVALID & MEM_RREADY;
   assign cnt_last = (cnt == LAST_CNT);
   // RLAST ends the burst; so does the final counted beat, even if the
   // slave never raises RLAST.
   assign r_done   = r_hs & (MEM_RLAST | cnt_last);
   assign idx      = cnt[IW-1:0];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept)             state_nxt = req_wr ? S_AW : S_AR;
         S_AW:   if (MEM_AWREADY)        state_nxt = S_W;
         S_W:    if (w_hs && cnt_last)   state_nxt = S_B;
         S_B:    if (MEM_BVALID)         state_nxt = S_RSP;
         S_AR:   if (MEM_ARREADY)        state_nxt = S_R;
         S_R:    if (r_done)             state_nxt = S_RSP;
         S_RSP:                          state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      MEM_AWVALID = 1'b0;
      MEM_WVALID  = 1'b0;
      MEM_WLAST   = 1'b0;
      MEM_BREADY  = 1'b0;
      MEM_ARVALID = 1'b0;
      MEM_RREADY  = 1'b0;
      case (state)
         S_IDLE: req_ready   = started;
         S_AW:   MEM_AWVALID = 1'b1;
         S_W: begin
            MEM_WVALID = 1'b1;
            MEM_WLAST  = cnt_last;
         end
         S_B:    MEM_BREADY  = 1'b1;
         S_AR:   MEM_ARVALID = 1'b1;
         S_R:    MEM_RREADY  = 1'b1;
         S_RSP:  rsp_valid   = 1'b1;
         default: ;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) started <= 1'b0;
      else       started <= 1'b1;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         addr     <= '0;
         cnt      <= '0;
         line_buf <= '0;
      end else if (accept) begin
         addr     <= req_addr & ADDR_MASK;
         cnt      <= '0;
         line_buf <= req_wdata;
      end else begin
         if (state == S_W && w_hs) cnt <= cnt + 8'd1;
         if (state == S_R && r_hs) begin
            line_buf[idx] <= MEM_RDATA;
            cnt           <= cnt + 8'd1;
         end
      end
   end

`ifdef AXI_MST_RESP_CHK_EN
   logic err;

   // Reads accumulate: any non-OKAY beat, or RLAST not lining up with the
   // final counted beat (early or missing), flags the line as bad.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         err <= 1'b0;
      end else if (accept) begin
         err <= 1'b0;
      end else if (state == S_B && MEM_BVALID) begin
         err <= (MEM_BRESP != 2'b00);
      end else if (state == S_R && r_hs) begin
         err <= err | (MEM_RRESP != 2'b00) | (MEM_RLAST != cnt_last);
      end
   end

   assign rsp_err = err;
`else
   logic unused_resp;
   assign unused_resp = ^{MEM_BRESP, MEM_RRESP};
   assign rsp_err     = 1'b0;
`endif

   assign rsp_rdata   = line_buf;
   assign MEM_WDATA   = line_buf[idx];
   assign MEM_WSTRB   = '1;
   assign MEM_AWADDR  = addr;
   assign MEM_ARADDR  = addr;
   assign MEM_AWLEN   = LAST_CNT;
   assign MEM_ARLEN   = LAST_CNT;
   assign MEM_AWSIZE  = 3'($clog2(DW / 8));
   assign MEM_ARSIZE  = 3'($clog2(DW / 8));
   assign MEM_AWBURST = 2'b01;
   assign MEM_ARBURST = 2'b01;

endmodule

// File: tb/tb_axi_full_mst_line.sv
// Self-checking bench for axi_full_mst_line (DW=64, BEAT_NUM=8).
// A table of line transactions is run through a lockstep AXI slave driven
// on the falling edge; hand-written sequences cover back-to-back requests
// and reset in the middle of a write burst.
module tb_axi_full_mst_line;

   localparam int DW = 64;
   localparam int BN = 8;
`ifdef AXI_MST_RESP_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic            CLK, RSTn;
   logic            req_valid, req_ready, req_wr;
   logic [31:0]     req_addr;
   logic [DW*BN-1:0] req_wdata;
   logic            rsp_valid, rsp_err;
   logic [DW*BN-1:0] rsp_rdata;
   logic [31:0]     MEM_AWADDR, MEM_ARADDR;
   logic [7:0]      MEM_AWLEN, MEM_ARLEN;
   logic [2:0]      MEM_AWSIZE, MEM_ARSIZE;
   logic [1:0]      MEM_AWBURST, MEM_ARBURST, MEM_BRESP, MEM_RRESP;
   logic            MEM_AWVALID, MEM_AWREADY, MEM_WLAST, MEM_WVALID, MEM_WREADY;
   logic            MEM_BVALID, MEM_BREADY, MEM_ARVALID, MEM_ARREADY;
   logic            MEM_RLAST, MEM_RVALID, MEM_RREADY;
   logic [DW-1:0]   MEM_WDATA, MEM_RDATA;
   logic [DW/8-1:0] MEM_WSTRB;

   axi_full_mst_line #(.DW(DW), .BEAT_NUM(BN)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN), .MEM_AWSIZE(MEM_AWSIZE),
      .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
      .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
      .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
      .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
      .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN), .MEM_ARSIZE(MEM_ARSIZE),
      .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
      .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
      .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] exp_addr;
      logic [63:0] base;       // write beat i / read RDATA i = base + i
      logic [1:0]  resp;       // BRESP, or RRESP on beat resp_beat
      int          resp_beat;
      int          nbeats;     // R beats the slave sends
      int          rlast_at;   // beat carrying RLAST (-1: never)
      bit          err;        // expected rsp_err with checking enabled
   } vec_t;

   localparam logic [63:0] FILL = 64'hDEAD_BEEF_0000_0000;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_req(input vec_t v, input bit hold);
      @(negedge CLK);
      req_valid = 1'b1;
      req_wr    = v.wr;
      req_addr  = v.addr;
      for (int j = 0; j < BN; j++)
         req_wdata[j*DW +: DW] = v.wr ? v.base + 64'(j) : FILL + 64'(j);
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      @(negedge CLK);
      req_valid = hold;
   endtask

   // Called at the negedge where rsp_valid is expected.
   task automatic finish_chk(input vec_t v);
      logic [63:0] exp;
      chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("rsp_err", {63'd0, rsp_err}, {63'd0, CHK_EN & v.err});
      for (int j = 0; j < BN; j++) begin
         exp = (v.wr || j < v.nbeats) ? v.base + 64'(j) : FILL + 64'(j);
         chk($sformatf("rsp_rdata[%0d]", j), rsp_rdata[j*DW +: DW], exp);
      end
      @(negedge CLK);
      chk("rsp_pulse_one_cycle", {63'd0, rsp_valid}, 64'd0);
      chk("req_ready_after_rsp", {63'd0, req_ready}, 64'd1);
   endtask

   task automatic write_body(input vec_t v);
      chk("awvalid", {63'd0, MEM_AWVALID}, 64'd1);
      chk("wvalid_during_aw", {63'd0, MEM_WVALID}, 64'd0);
      chk("arvalid_on_write", {63'd0, MEM_ARVALID}, 64'd0);
      chk("awaddr", {32'd0, MEM_AWADDR}, {32'd0, v.exp_addr});
      chk("awlen", {56'd0, MEM_AWLEN}, 64'd7);
      chk("awsize", {61'd0, MEM_AWSIZE}, 64'd3);
      chk("awburst", {62'd0, MEM_AWBURST}, 64'd1);
      MEM_AWREADY = 1'b1;
      @(negedge CLK);
      MEM_AWREADY = 1'b0;
      MEM_WREADY  = 1'b1;
      for (int i = 0; i < BN; i++) begin
         chk($sformatf("wvalid[%0d]", i), {63'd0, MEM_WVALID}, 64'd1);
         chk($sformatf("awvalid_off[%0d]", i), {63'd0, MEM_AWVALID}, 64'd0);
         chk($sformatf("wdata[%0d]", i), MEM_WDATA, v.base + 64'(i));
         chk($sformatf("wlast[%0d]", i), {63'd0, MEM_WLAST}, {63'd0, i == BN - 1});
         chk($sformatf("wstrb[%0d]", i), {56'd0, MEM_WSTRB}, 64'hFF);
         chk($sformatf("req_ready_busy[%0d]", i), {63'd0, req_ready}, 64'd0);
         @(negedge CLK);
      end
      MEM_WREADY = 1'b0;
      chk("wvalid_after_last", {63'd0, MEM_WVALID}, 64'd0);
      chk("bready", {63'd0, MEM_BREADY}, 64'd1);
      MEM_BVALID = 1'b1;
      MEM_BRESP  = v.resp;
      @(negedge CLK);
      MEM_BVALID = 1'b0;
      MEM_BRESP  = 2'b00;
      finish_chk(v);
   endtask

   task automatic read_body(input vec_t v);
      chk("arvalid", {63'd0, MEM_ARVALID}, 64'd1);
      chk("awvalid_on_read", {63'd0, MEM_AWVALID}, 64'd0);
      chk("araddr", {32'd0, MEM_ARADDR}, {32'd0, v.exp_addr});
      chk("arlen", {56'd0, MEM_ARLEN}, 64'd7);
      chk("arsize", {61'd0, MEM_ARSIZE}, 64'd3);
      chk("arburst", {62'd0, MEM_ARBURST}, 64'd1);
      MEM_ARREADY = 1'b1;
      @(negedge CLK);
      MEM_ARREADY = 1'b0;
      chk("arvalid_after_hs", {63'd0, MEM_ARVALID}, 64'd0);
      chk("rready", {63'd0, MEM_RREADY}, 64'd1);
      for (int i = 0; i < v.nbeats; i++) begin
         for (int g = 0; g < (i * 3 + 1) % 4; g++) begin
            MEM_RVALID = 1'b0;
            @(negedge CLK);
            chk($sformatf("no_early_rsp[%0d]", i), {63'd0, rsp_valid}, 64'd0);
         end
         MEM_RVALID = 1'b1;
         MEM_RDATA  = v.base + 64'(i);
         MEM_RRESP  = (i == v.resp_beat) ? v.resp : 2'b00;
         MEM_RLAST  = (i == v.rlast_at);
         @(negedge CLK);
      end
      MEM_RVALID = 1'b0;
      MEM_RLAST  = 1'b0;
      MEM_RRESP  = 2'b00;
      finish_chk(v);
   endtask

   task automatic run_vec(input vec_t v);
      send_req(v, 1'b0);
      if (v.wr) write_body(v);
      else      read_body(v);
   endtask

   vec_t vecs[7];
   vec_t vb_w, vb_r;

   initial begin
      vecs[0] = '{1'b1, 32'h8000_0040, 32'h8000_0040, 64'h1111_0000_0000_0000, 2'b00, 0, 8,  7, 1'b0};
      vecs[1] = '{1'b0, 32'h8000_0077, 32'h8000_0040, 64'h2222_0000_0000_0000, 2'b00, 0, 8,  7, 1'b0};
      vecs[2] = '{1'b1, 32'h1234_5678, 32'h1234_5640, 64'h3333_0000_0000_0000, 2'b10, 0, 8,  7, 1'b1};
      vecs[3] = '{1'b0, 32'h0000_0FFF, 32'h0000_0FC0, 64'h4444_0000_0000_0000, 2'b00, 0, 4,  3, 1'b1};
      vecs[4] = '{1'b0, 32'hA000_0001, 32'hA000_0000, 64'h5555_0000_0000_0000, 2'b00, 0, 8, -1, 1'b1};
      vecs[5] = '{1'b0, 32'h0000_1080, 32'h0000_1080, 64'h6666_0000_0000_0000, 2'b10, 2, 8,  7, 1'b1};
      vecs[6] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFC0, 64'h7777_0000_0000_0000, 2'b11, 0, 8,  7, 1'b1};

      RSTn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
      MEM_AWREADY = 1'b0; MEM_WREADY = 1'b0; MEM_BVALID = 1'b0; MEM_BRESP = 2'b00;
      MEM_ARREADY = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0; MEM_RRESP = 2'b00;
      MEM_RLAST = 1'b0;

      // reset state
      repeat (2) @(negedge CLK);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_valids", {58'd0, MEM_AWVALID, MEM_WVALID, MEM_WLAST, MEM_BREADY,
                         MEM_ARVALID, MEM_RREADY}, 64'd0);
      chk("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
      chk("rst_rdata0", rsp_rdata[63:0], 64'd0);
      RSTn = 1'b1;
      #1 chk("rel_req_ready_pre_clk", {63'd0, req_ready}, 64'd0);
      @(negedge CLK);
      chk("rel_req_ready", {63'd0, req_ready}, 64'd1);

      // table of transactions
      for (int k = 0; k < 7; k++) run_vec(vecs[k]);

      // request held high through a busy write; the queued read is taken
      // the cycle req_ready returns and issues AR the next cycle
      vb_w = vecs[0];
      vb_w.base = 64'h8888_0000_0000_0000;
      vb_r = vecs[1];
      vb_r.base = 64'h9999_0000_0000_0000;
      send_req(vb_w, 1'b1);
      req_wr   = 1'b0;
      req_addr = vb_r.addr;
      for (int j = 0; j < BN; j++) req_wdata[j*DW +: DW] = FILL + 64'(j);
      write_body(vb_w);
      @(negedge CLK);
      req_valid = 1'b0;
      read_body(vb_r);

      // reset during the third W beat
      send_req(vecs[0], 1'b0);
      MEM_AWREADY = 1'b1;
      @(negedge CLK);
      MEM_AWREADY = 1'b0;
      MEM_WREADY  = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("w3_wvalid_before_rst", {63'd0, MEM_WVALID}, 64'd1);
      #2 RSTn = 1'b0;
      #1;
      chk("rst_mid_wvalid", {63'd0, MEM_WVALID}, 64'd0);
      chk("rst_mid_wlast", {63'd0, MEM_WLAST}, 64'd0);
      chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_mid_req_ready", {63'd0, req_ready}, 64'd0);
      MEM_WREADY = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_mid_held_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      RSTn = 1'b1;
      @(negedge CLK);
      chk("rst_mid_idle_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_mid_no_rsp", {63'd0, rsp_valid}, 64'd0);
      chk("rst_mid_buf_cleared", rsp_rdata[63:0], 64'd0);
      run_vec(vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
